// File: rtl/doled_pkg.sv
// Shared definitions for the doled strip path: frame type codes used by the
// sequencer and the LED stage, plus the sequencer state encoding.
package doled_pkg;

  // Frame type presented to the LED stage on type_out.
  typedef enum logic [1:0] {
    FRAME_START = 2'd0,
    FRAME_LED   = 2'd1,
    FRAME_END   = 2'd2
  } frame_type_t;

  // Sequencer states; encodings 9..15 are unreachable and recover to IDLE.
  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_SEND_START  = 4'd1,
    ST_FETCH       = 4'd2,
    ST_FETCH_WAIT  = 4'd3,
    ST_ISSUE       = 4'd4,
    ST_WAIT_ACCEPT = 4'd5,
    ST_WAIT_DONE   = 4'd6,
    ST_SEND_END    = 4'd7,
    ST_DONE        = 4'd8
  } seq_state_t;

  localparam logic [7:0] COLOUR_START = 8'h00;
  localparam logic [7:0] COLOUR_END   = 8'hFF;

endpackage

// File: rtl/strip_sequencer_if.sv
// Pixel-memory read port and LED-stage request port of the strip sequencer.
//
// Handshakes:
//   pixel memory: pix_rd is a one-cycle read strobe with pix_addr; pix_data is
//     valid on the cycle after pix_rd, no back-pressure.
//   LED stage: the sequencer raises doled_start only while doled_busy is 0 and
//     holds it, with type/colour stable, until doled_busy=1 is sampled; the
//     stage keeps doled_busy high for the whole frame and drops it when done.
interface strip_sequencer_if;
  logic [9:0]  pix_addr;
  logic        pix_rd;
  logic [23:0] pix_data;
  logic [1:0]  type_out;
  logic [7:0]  red_out;
  logic [7:0]  green_out;
  logic [7:0]  blue_out;
  logic        doled_start;
  logic        doled_busy;

  modport master (
    output pix_addr, pix_rd, type_out, red_out, green_out, blue_out, doled_start,
    input  pix_data, doled_busy
  );

  modport slave (
    input  pix_addr, pix_rd, type_out, red_out, green_out, blue_out, doled_start,
    output pix_data, doled_busy
  );
endinterface

// File: rtl/strip_sequencer.sv
// Strip sequencer: on frame_go sends one START frame, NUM_LEDS LED frames read
// from pixel memory, and END_FRAMES END frames to the LED stage, one frame per
// start/busy handshake, then pulses frame_done.
module strip_sequencer
  import doled_pkg::*;
#(
  parameter int NUM_LEDS   = 60,
  parameter int END_FRAMES = 1
) (
  input  logic              doled_clk,
  input  logic              doled_reset,
  input  logic              frame_go,
  output logic              frame_busy,
  output logic              frame_done,
  output logic [3:0]        dbg_state,
  strip_sequencer_if.master strip
);

  localparam logic [9:0] LAST_IDX  = 10'(NUM_LEDS - 1);
  localparam logic [4:0] END_LIMIT = 5'(END_FRAMES);

  seq_state_t  state;
  seq_state_t  state_next;
  frame_type_t type_q;
  logic [7:0]  red_q;
  logic [7:0]  green_q;
  logic [7:0]  blue_q;
  logic [9:0]  led_idx;
  logic [4:0]  end_cnt;

  // State register.
  always_ff @(posedge doled_clk or posedge doled_reset) begin
    if (doled_reset) state <= ST_IDLE;
    else             state <= state_next;
  end

  // Next-state logic; the frame just completed (type_q) picks the successor.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:        if (frame_go) state_next = ST_SEND_START;
      ST_SEND_START:  state_next = ST_ISSUE;
      ST_FETCH:       state_next = ST_FETCH_WAIT;
      ST_FETCH_WAIT:  state_next = ST_ISSUE;
      ST_ISSUE:       if (!strip.doled_busy) state_next = ST_WAIT_ACCEPT;
      ST_WAIT_ACCEPT: if (strip.doled_busy) state_next = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (!strip.doled_busy) begin
          case (type_q)
            FRAME_START: state_next = ST_FETCH;
            FRAME_LED:   state_next = (led_idx == LAST_IDX) ? ST_SEND_END : ST_FETCH;
            default:     state_next = (end_cnt < END_LIMIT) ? ST_SEND_END : ST_DONE;
          endcase
        end
      end
      ST_SEND_END:    state_next = ST_ISSUE;
      ST_DONE:        state_next = ST_IDLE;
      default:        state_next = ST_IDLE;
    endcase
  end

  // Control outputs decoded from the current state; unknown encodings give 0.
  always_comb begin
    frame_busy        = 1'b0;
    frame_done        = 1'b0;
    strip.pix_rd      = 1'b0;
    strip.doled_start = 1'b0;
    case (state)
      ST_SEND_START, ST_FETCH_WAIT, ST_ISSUE, ST_WAIT_DONE, ST_SEND_END:
        frame_busy = 1'b1;
      ST_FETCH: begin
        frame_busy   = 1'b1;
        strip.pix_rd = 1'b1;
      end
      ST_WAIT_ACCEPT: begin
        frame_busy        = 1'b1;
        strip.doled_start = 1'b1;
      end
      ST_DONE:
        frame_done = 1'b1;
      default: ;
    endcase
  end

  // Frame payload and counters; only updated in the load states, so the
  // payload is frozen across ISSUE/WAIT_ACCEPT/WAIT_DONE.
  always_ff @(posedge doled_clk or posedge doled_reset) begin
    if (doled_reset) begin
      type_q  <= FRAME_START;
      red_q   <= 8'h00;
      green_q <= 8'h00;
      blue_q  <= 8'h00;
      led_idx <= 10'd0;
      end_cnt <= 5'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_go) begin
            led_idx <= 10'd0;
            end_cnt <= 5'd0;
          end
        end
        ST_SEND_START: begin
          type_q  <= FRAME_START;
          red_q   <= COLOUR_START;
          green_q <= COLOUR_START;
          blue_q  <= COLOUR_START;
        end
        ST_FETCH_WAIT: begin
          type_q  <= FRAME_LED;
          red_q   <= strip.pix_data[23:16];
          green_q <= strip.pix_data[15:8];
          blue_q  <= strip.pix_data[7:0];
        end
        ST_WAIT_DONE: begin
          if (!strip.doled_busy) begin
            if (type_q == FRAME_START) led_idx <= 10'd0;
            else if (type_q == FRAME_LED && led_idx != LAST_IDX) led_idx <= led_idx + 10'd1;
          end
        end
        ST_SEND_END: begin
          type_q  <= FRAME_END;
          red_q   <= COLOUR_END;
          green_q <= COLOUR_END;
          blue_q  <= COLOUR_END;
          end_cnt <= end_cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign strip.pix_addr  = led_idx;
  assign strip.type_out  = type_q;
  assign strip.red_out   = red_q;
  assign strip.green_out = green_q;
  assign strip.blue_out  = blue_q;
  assign dbg_state       = state;

endmodule

// File: tb/tb_strip_sequencer.sv
// Bench for strip_sequencer: two instances (3 LEDs / 1 END and 1 LED / 4 END),
// each with a pixel memory model and a 40-cycle LED-stage model.
module tb_strip_sequencer;
  import doled_pkg::*;

  typedef struct {
    logic [23:0] pix;   // memory word feeding this frame (LED frames only)
    logic [1:0]  typ;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
  } vec_t;

  logic doled_clk;
  logic doled_reset;
  logic go_a, go_b;
  logic busy_a, busy_b, done_a_o, done_b_o;
  logic [3:0] st_a, st_b;
  logic hold_b;

  strip_sequencer_if ifc_a ();
  strip_sequencer_if ifc_b ();

  strip_sequencer #(.NUM_LEDS(3), .END_FRAMES(1)) dut_a (
    .doled_clk(doled_clk), .doled_reset(doled_reset), .frame_go(go_a),
    .frame_busy(busy_a), .frame_done(done_a_o), .dbg_state(st_a), .strip(ifc_a.master)
  );

  strip_sequencer #(.NUM_LEDS(1), .END_FRAMES(4)) dut_b (
    .doled_clk(doled_clk), .doled_reset(doled_reset), .frame_go(go_b),
    .frame_busy(busy_b), .frame_done(done_b_o), .dbg_state(st_b), .strip(ifc_b.master)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  initial doled_clk = 1'b0;
  always #5 doled_clk = ~doled_clk;

  // ---------------- pixel memories ----------------
  logic [23:0] mem_a [0:3];
  logic [23:0] mem_b [0:1];
  int rd_cnt_b = 0;
  int addr_err_b = 0;

  always @(posedge doled_clk) begin
    if (ifc_a.pix_rd) ifc_a.pix_data <= mem_a[ifc_a.pix_addr[1:0]];
    if (ifc_b.pix_rd) begin
      ifc_b.pix_data <= mem_b[ifc_b.pix_addr[0]];
      rd_cnt_b++;
      if (ifc_b.pix_addr != 10'd0) addr_err_b++;
    end
  end

  // ---------------- LED-stage models ----------------
  logic        mbusy_a, mbusy_b;
  int          cnt_a, cnt_b, age_a, age_b;
  logic [25:0] rec_a, rec_b;
  logic [25:0] act_a[$];
  logic [25:0] act_b[$];
  int stab_err_a = 0, stab_err_b = 0, drop_err_a = 0, drop_err_b = 0;
  int done_a = 0, done_b = 0;

  assign ifc_a.doled_busy = mbusy_a;
  assign ifc_b.doled_busy = mbusy_b | hold_b;

  always @(posedge doled_clk or posedge doled_reset) begin
    if (doled_reset) begin
      mbusy_a <= 1'b0; cnt_a <= 0; age_a <= 0;
    end else if (!mbusy_a) begin
      if (ifc_a.doled_start) begin
        rec_a   <= {ifc_a.type_out, ifc_a.red_out, ifc_a.green_out, ifc_a.blue_out};
        act_a.push_back({ifc_a.type_out, ifc_a.red_out, ifc_a.green_out, ifc_a.blue_out});
        mbusy_a <= 1'b1; cnt_a <= 40; age_a <= 0;
      end
    end else begin
      if ({ifc_a.type_out, ifc_a.red_out, ifc_a.green_out, ifc_a.blue_out} != rec_a) stab_err_a++;
      if (age_a == 1 && ifc_a.doled_start) drop_err_a++;
      age_a <= age_a + 1;
      if (cnt_a == 1) mbusy_a <= 1'b0;
      cnt_a <= cnt_a - 1;
    end
  end

  always @(posedge doled_clk or posedge doled_reset) begin
    if (doled_reset) begin
      mbusy_b <= 1'b0; cnt_b <= 0; age_b <= 0;
    end else if (!mbusy_b) begin
      if (ifc_b.doled_start && !hold_b) begin
        rec_b   <= {ifc_b.type_out, ifc_b.red_out, ifc_b.green_out, ifc_b.blue_out};
        act_b.push_back({ifc_b.type_out, ifc_b.red_out, ifc_b.green_out, ifc_b.blue_out});
        mbusy_b <= 1'b1; cnt_b <= 40; age_b <= 0;
      end
    end else begin
      if ({ifc_b.type_out, ifc_b.red_out, ifc_b.green_out, ifc_b.blue_out} != rec_b) stab_err_b++;
      if (age_b == 1 && ifc_b.doled_start) drop_err_b++;
      age_b <= age_b + 1;
      if (cnt_b == 1) mbusy_b <= 1'b0;
      cnt_b <= cnt_b - 1;
    end
  end

  // Completion pulse counters.
  always @(posedge doled_clk) begin
    if (done_a_o) done_a++;
    if (done_b_o) done_b++;
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge doled_clk);
  endtask

  task automatic pulse_go_a();
    go_a = 1'b1; @(negedge doled_clk); go_a = 1'b0;
  endtask

  task automatic wait_done_a(input int base, input string name);
    int c;
    c = 0;
    while (done_a == base && c < 2000) begin @(negedge doled_clk); c++; end
    check(name, 32'(done_a - base), 32'd1);
  endtask

  task automatic wait_done_b(input int base, input string name);
    int c;
    c = 0;
    while (done_b == base && c < 2000) begin @(negedge doled_clk); c++; end
    check(name, 32'(done_b - base), 32'd1);
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_busy"},  32'(busy_a), 32'd0);
    check({tag, "_done"},  32'(done_a_o), 32'd0);
    check({tag, "_start"}, 32'(ifc_a.doled_start), 32'd0);
    check({tag, "_rd"},    32'(ifc_a.pix_rd), 32'd0);
    check({tag, "_addr"},  32'(ifc_a.pix_addr), 32'd0);
    check({tag, "_type"},  32'(ifc_a.type_out), 32'd0);
    check({tag, "_rgb"},   {8'h0, ifc_a.red_out, ifc_a.green_out, ifc_a.blue_out}, 32'd0);
    check({tag, "_state"}, 32'(st_a), 32'(ST_IDLE));
  endtask

  vec_t tbl_a [5];
  vec_t tbl_b [6];
  logic [25:0] exp_q[$];

  task automatic check_txns_a(input string tag);
    exp_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back({tbl_a[i].typ, tbl_a[i].r, tbl_a[i].g, tbl_a[i].b});
    check({tag, "_count"}, 32'(act_a.size()), 32'd5);
    for (int i = 0; i < 5 && i < act_a.size(); i++)
      check($sformatf("%s_txn%0d", tag, i), 32'(act_a[i]), 32'(exp_q[i]));
    check({tag, "_stable"}, 32'(stab_err_a), 32'd0);
    check({tag, "_start_drop"}, 32'(drop_err_a), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int base;
    int seen;
    int c;

    tbl_a[0] = '{pix: 24'h000000, typ: 2'd0, r: 8'h00, g: 8'h00, b: 8'h00};
    tbl_a[1] = '{pix: 24'h112233, typ: 2'd1, r: 8'h11, g: 8'h22, b: 8'h33};
    tbl_a[2] = '{pix: 24'h445566, typ: 2'd1, r: 8'h44, g: 8'h55, b: 8'h66};
    tbl_a[3] = '{pix: 24'h778899, typ: 2'd1, r: 8'h77, g: 8'h88, b: 8'h99};
    tbl_a[4] = '{pix: 24'h000000, typ: 2'd2, r: 8'hFF, g: 8'hFF, b: 8'hFF};
    tbl_b[0] = '{pix: 24'h000000, typ: 2'd0, r: 8'h00, g: 8'h00, b: 8'h00};
    tbl_b[1] = '{pix: 24'hA1B2C3, typ: 2'd1, r: 8'hA1, g: 8'hB2, b: 8'hC3};
    for (int i = 2; i < 6; i++)
      tbl_b[i] = '{pix: 24'h000000, typ: 2'd2, r: 8'hFF, g: 8'hFF, b: 8'hFF};

    for (int i = 0; i < 3; i++) mem_a[i] = tbl_a[i+1].pix;
    mem_a[3] = 24'hBADBAD;
    mem_b[0] = tbl_b[1].pix;
    mem_b[1] = 24'hDEAD00;

    go_a = 1'b0; go_b = 1'b0; hold_b = 1'b0;
    doled_reset = 1'b1;
    cycles(3);
    check_reset_a("reset");
    doled_reset = 1'b0;
    cycles(2);

    // Basic update, 3 LEDs.
    act_a.delete();
    base = done_a;
    pulse_go_a();
    check("busy_after_go", 32'(busy_a), 32'd1);
    wait_done_a(base, "t1_done");
    @(negedge doled_clk);
    check("t1_busy_clear", 32'(busy_a), 32'd0);
    check_txns_a("t1");

    // Second frame_go in mid-update is ignored.
    act_a.delete();
    base = done_a;
    pulse_go_a();
    cycles(100);
    pulse_go_a();
    wait_done_a(base, "t2_done");
    cycles(300);
    check("t2_single_done", 32'(done_a - base), 32'd1);
    check("t2_idle", 32'(st_a), 32'(ST_IDLE));
    check_txns_a("t2");

    // Reset during the 2nd LED frame.
    act_a.delete();
    base = done_a;
    pulse_go_a();
    c = 0;
    while (act_a.size() < 3 && c < 1000) begin @(negedge doled_clk); c++; end
    check("t3_reached_led2", 32'(act_a.size()), 32'd3);
    cycles(5);
    doled_reset = 1'b1;
    #1;
    check_reset_a("t3_mid_reset");
    cycles(3);
    doled_reset = 1'b0;
    cycles(300);
    check("t3_no_done", 32'(done_a - base), 32'd0);
    act_a.delete();
    pulse_go_a();
    wait_done_a(base, "t3_done");
    check_txns_a("t3");

    // One LED, four END frames, LED stage busy when frame_go arrives.
    act_b.delete();
    rd_cnt_b = 0;
    addr_err_b = 0;
    base = done_b;
    hold_b = 1'b1;
    cycles(2);
    go_b = 1'b1; @(negedge doled_clk); go_b = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge doled_clk);
      if (ifc_b.doled_start) seen++;
    end
    check("t4_start_held_low", 32'(seen), 32'd0);
    check("t4_in_issue", 32'(st_b), 32'(ST_ISSUE));
    hold_b = 1'b0;
    wait_done_b(base, "t4_done");
    check("t4_count", 32'(act_b.size()), 32'd6);
    for (int i = 0; i < 6 && i < act_b.size(); i++)
      check($sformatf("t4_txn%0d", i), 32'(act_b[i]),
            32'({tbl_b[i].typ, tbl_b[i].r, tbl_b[i].g, tbl_b[i].b}));
    check("t4_addr_zero", 32'(addr_err_b), 32'd0);
    check("t4_one_read", 32'(rd_cnt_b), 32'd1);
    check("t4_stable", 32'(stab_err_b), 32'd0);
    check("t4_start_drop", 32'(drop_err_b), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/strip_sequencer.md
STRIP_SEQUENCER -- requirements
Module: strip_sequencer

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 60: number of LED frames per strip update, range 1..1023.
REQ-002 SHALL have parameter END_FRAMES, default 1: number of END frames sent after the last LED frame, range 1..16.
REQ-003 doled_clk  input  1  clock; all logic on rising edge.
REQ-004 doled_reset  input  1  reset, asynchronous, active-high.
REQ-005 frame_go  input  1  single-cycle request to send one full strip update.
REQ-006 frame_busy  output  1  high from acceptance of frame_go until the update completes.
REQ-007 frame_done  output  1  one-cycle pulse when the update completes.
REQ-008 pix_addr  output  10  pixel memory read address.
REQ-009 pix_rd  output  1  pixel memory read enable.
REQ-010 pix_data  input  24  pixel word {red[23:16], green[15:8], blue[7:0]}, valid one cycle after pix_rd.
REQ-011 type_out  output  2  frame type to the LED stage: 0 START, 1 LED, 2 END.
REQ-012 red_out, green_out, blue_out  output  8 each  colour bytes to the LED stage.
REQ-013 doled_start  output  1  request to the LED stage.
REQ-014 doled_busy  input  1  LED stage busy.

Function
REQ-015 States SHALL be: IDLE, SEND_START, FETCH, FETCH_WAIT, ISSUE, WAIT_ACCEPT, WAIT_DONE, SEND_END, DONE.
REQ-016 IDLE: frame_go=1 SHALL go to SEND_START and set frame_busy=1; frame_go while frame_busy=1 SHALL be ignored.
REQ-017 SEND_START: type_out=0 and colour outputs=0x00, then go to ISSUE.
REQ-018 FETCH: pix_rd=1 for one cycle with pix_addr=led_idx; FETCH_WAIT then captures pix_data into red/green/blue_out, sets type_out=1, and goes to ISSUE.
REQ-019 ISSUE: wait until doled_busy=0, then set doled_start=1 and go to WAIT_ACCEPT.
REQ-020 WAIT_ACCEPT: hold doled_start=1 until doled_busy=1 is sampled, then drop doled_start and go to WAIT_DONE.
REQ-021 WAIT_DONE: on doled_busy=0, advance: after START go to FETCH with led_idx=0; after an LED frame go to FETCH with led_idx+1, or to SEND_END if led_idx=NUM_LEDS-1; after an END frame go to SEND_END if end_cnt<END_FRAMES, else go to DONE.
REQ-022 SEND_END: type_out=2, colour outputs=0xFF, end_cnt+1, then go to ISSUE.
REQ-023 DONE: pulse frame_done=1 for one cycle, clear frame_busy, go to IDLE.
REQ-024 type_out and colour outputs SHALL stay stable from doled_start rising until the matching doled_busy falls.
REQ-025 led_idx SHALL be a 10-bit counter that never exceeds NUM_LEDS-1 and never wraps; end_cnt SHALL be 5-bit.
REQ-026 Total LED-stage transactions per update SHALL be exactly 1+NUM_LEDS+END_FRAMES.
REQ-027 NUM_LEDS=1 SHALL send START, one LED frame from address 0, then the END frames.
REQ-028 pix_rd SHALL be 0 in every state except FETCH.
REQ-029 An unreachable state encoding SHALL return to IDLE with doled_start=0 and frame_busy=0.

Reset
REQ-030 doled_reset SHALL force state IDLE; frame_busy, frame_done, doled_start, pix_rd, pix_addr, type_out, colour outputs, led_idx and end_cnt SHALL all be 0.
REQ-031 A reset mid-update SHALL abandon the update without a frame_done pulse; the next frame_go SHALL restart from SEND_START.

Structure
REQ-032 The frame type codes (START=0, LED=1, END=2) SHALL live in shared package doled_pkg, used by this block and the LED stage.
REQ-033 This block SHALL have no sub-module; the LED stage SHALL be instantiated beside it at the strip top level.

Verification
REQ-034 NUM_LEDS=3, END_FRAMES=1, memory {0x112233, 0x445566, 0x778899}, frame_go -> five transactions: type 0 with 00/00/00; type 1 with R11 G22 B33; type 1 with R44 G55 B66; type 1 with R77 G88 B99; type 2 with FF/FF/FF; then one frame_done.
REQ-035 Bench LED-stage model holds doled_busy high for 40 cycles per transaction -> doled_start falls the cycle after busy=1 is sampled, and outputs stay stable for all 40 cycles.
REQ-036 frame_go pulsed again during an update -> ignored; exactly one frame_done and 5 transactions.
REQ-037 doled_reset asserted during the 2nd LED frame -> all outputs 0 immediately, no frame_done; the next frame_go yields a full 5-transaction update.
REQ-038 NUM_LEDS=1, END_FRAMES=4, doled_busy already 1 when frame_go arrives -> doled_start stays 0 until busy=0; then 6 transactions in total and pix_addr is only ever 0.
